// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache answering the IF stage's per-cycle fetch.
// Hits are served combinationally; a miss stalls IF while one full line is fetched from memory.
module icache_fetch_responder #(
  parameter int          NUM_LINES  = 4,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic                     flush,
  output logic [31:0]              instr_out,
  output logic                     icache_stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ready,
  output logic                     state_dbg
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF       = WORD_BITS + 2;
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_LSB   = OFF + IDX_BITS;
  localparam int TAG_BITS  = 32 - TAG_LSB;

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               pend_addr_q, pend_addr_d;
  logic                      drop_q, drop_d;
  logic [NUM_LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]       tag_q  [NUM_LINES];
  logic [32*LINE_WORDS-1:0]  data_q [NUM_LINES];

  logic [IDX_BITS-1:0]       idx;
  logic [TAG_BITS-1:0]       tag;
  logic [WORD_BITS-1:0]      word_sel;
  logic [IDX_BITS-1:0]       pend_idx;
  logic                      hit;
  logic                      fill_we;
  logic                      unused_pc_bits;

  assign idx            = pc[TAG_LSB-1:OFF];
  assign tag            = pc[31:TAG_LSB];
  assign word_sel       = pc[OFF-1:2];
  assign pend_idx       = pend_addr_q[TAG_LSB-1:OFF];
  assign hit            = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_pc_bits = ^pc[1:0];
  assign state_dbg      = (state_q == ST_REQ);

  // Memory handshake: mem_req/mem_addr stay asserted and stable from the first REQ
  // cycle until the cycle mem_ready is high; that cycle transfers the whole line.
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    drop_d       = drop_q;
    fill_we      = 1'b0;
    instr_out    = NOP_INSTR;
    icache_stall = 1'b1;
    mem_req      = 1'b0;
    mem_addr     = pend_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          icache_stall = 1'b0;
          instr_out    = data_q[idx][{word_sel, 5'b0} +: 32];
        end else begin
          pend_addr_d = {pc[31:OFF], {OFF{1'b0}}};
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          fill_we = 1'b1;
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      drop_q      <= drop_d;
    end
  end

  // A flush in the fill cycle wins, so that line is written but stays invalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[pend_idx] <= !drop_q;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_q[pend_idx]  <= pend_addr_q[31:TAG_LSB];
      data_q[pend_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder (4 lines x 4 words): cold miss, hits, eviction,
// redirect during a fill, flush in IDLE and REQ, and reset during an outstanding request.
module tb_icache_fetch_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clock;
  logic         reset;
  logic [31:0]  pc;
  logic         flush;
  logic [31:0]  instr_out;
  logic         icache_stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  icache_fetch_responder #(
    .NUM_LINES (4),
    .LINE_WORDS(4),
    .NOP_INSTR (NOP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .instr_out   (instr_out),
    .icache_stall(icache_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // memory model: line 0x1000 holds the program words, other lines hold addr ^ 0xA5000000
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] prog [4];
    prog[0] = 32'h00A0_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;
    if ({addr[31:4], 4'h0} == 32'h0000_1000) return prog[addr[3:2]];
    return {addr[31:2], 2'b00} ^ 32'hA500_0000;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] base);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = mem_word(base + 32'(4 * i));
    return d;
  endfunction

  // driver: serve the outstanding request after 'waits' non-ready REQ cycles
  task automatic fill(input int waits);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL fill_no_expected_request got=%0d exp=1", 0);
      return;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < waits; i++) begin
      check("req_wait", {31'b0, mem_req}, 32'd1);
      check("addr_wait", mem_addr, exp);
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = line_data(exp);
    #1;
    check("req_ready", {31'b0, mem_req}, 32'd1);
    check("addr_ready", mem_addr, exp);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic expect_miss(input string name);
    #1;
    check({name, "_stall"}, {31'b0, icache_stall}, 32'd1);
    check({name, "_nop"}, instr_out, NOP);
  endtask

  task automatic expect_hit(input string name, input logic [31:0] addr);
    #1;
    check({name, "_stall"}, {31'b0, icache_stall}, 32'd0);
    check({name, "_instr"}, instr_out, mem_word(addr));
    check({name, "_noreq"}, {31'b0, mem_req}, 32'd0);
  endtask

  task automatic miss_and_fill(input string name, input logic [31:0] addr, input int waits);
    pc = addr;
    exp_q.push_back({addr[31:4], 4'h0});
    expect_miss({name, "_miss"});
    tick();
    fill(waits);
    expect_hit({name, "_after"}, addr);
  endtask

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;

    // 1. cold miss
    pc = 32'h1000;
    #1;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_state", {31'b0, state_dbg}, 32'd0);
    miss_and_fill("cold", 32'h1000, 3);

    // 2. hits in the filled line
    tick(); pc = 32'h1004; expect_hit("hit4", 32'h1004);
    tick(); pc = 32'h1008; expect_hit("hit8", 32'h1008);

    // 3. conflict eviction on index 0
    tick(); miss_and_fill("evict", 32'h1040, 1);
    tick(); miss_and_fill("refill", 32'h1000, 2);

    // 4. redirect during REQ: fill completes for the latched line
    tick(); miss_and_fill("pre_redir", 32'h1040, 0);
    tick();
    pc = 32'h1000;
    exp_q.push_back(32'h1000);
    expect_miss("redir_miss");
    tick();
    pc = 32'h2000;
    fill(2);
    exp_q.push_back(32'h2000);
    expect_miss("redir_new");
    tick();
    fill(1);
    expect_hit("redir_hit", 32'h2000);
    // 0x2000 shares index 0 with 0x1000, so 0x1000 was evicted again
    tick(); miss_and_fill("redir_back", 32'h1000, 0);

    // 5A. flush in IDLE: hit in the flush cycle still served, then miss
    tick();
    flush = 1'b1;
    expect_hit("flush_idle_hit", 32'h1000);
    tick();
    flush = 1'b0;
    miss_and_fill("flush_idle", 32'h1000, 1);

    // 5B. flush during REQ: arriving line is left invalid
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back(32'h1000);
    expect_miss("flush_req_miss");
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fill(1);
    expect_miss("flush_req_dropped");
    exp_q.push_back(32'h1000);
    tick();
    fill(0);
    expect_hit("flush_req_refill", 32'h1000);

    // 6. reset mid-REQ
    tick(); miss_and_fill("pre_rst", 32'h1040, 0);
    tick();
    pc = 32'h1000;
    expect_miss("rst_req_miss");
    tick();
    check("rst_req_pending", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_req_drop", {31'b0, mem_req}, 32'd0);
    check("rst_req_addr", mem_addr, 32'h0);
    pc = 32'h1040;
    expect_miss("rst_invalidated");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
